// File: rtl/read_valid_pipe.sv
// Per-channel read-latency tracker: read enable -> read-valid strobe LATENCY cycles later, carrying a tag.
// Optional burst mode drops the first beat of each enable burst; in-flight counters and flush support drain/abort.
module read_valid_pipe #(
  parameter  int CHANNELS  = 4,
  parameter  int LATENCY   = 2,
  parameter  int TAG_WIDTH = 4,
  localparam int CNT_WIDTH = $clog2(LATENCY + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             readEnable,
  input  logic [CHANNELS*TAG_WIDTH-1:0]   readTag,
  input  logic [CHANNELS-1:0]             burstMode,
  input  logic                            flush,
  output logic [CHANNELS-1:0]             readValid,
  output logic [CHANNELS*TAG_WIDTH-1:0]   validTag,
  output logic [CHANNELS*CNT_WIDTH-1:0]   inFlight,
  output logic                            busy
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("read_valid_pipe: LATENCY must be at least 1");
  end

  logic [CHANNELS-1:0]  prev_en;
  logic [CHANNELS-1:0]  first_beat;
  logic [CHANNELS-1:0]  accept;
  logic [CHANNELS-1:0]  emit;
  logic [LATENCY-1:0]   stage_vld [CHANNELS];
  logic [TAG_WIDTH-1:0] stage_tag [CHANNELS][LATENCY];
  logic [CNT_WIDTH-1:0] cnt_q     [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d     [CHANNELS];
  logic                 busy_d;

  always_comb begin
    first_beat = readEnable & ~prev_en;
    accept     = readEnable & ~(burstMode & first_beat) & {CHANNELS{~flush}};
    busy_d     = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      emit[c]  = stage_vld[c][LATENCY-1];
      cnt_d[c] = cnt_q[c];
      if (flush) begin
        cnt_d[c] = '0;
      end else begin
        case ({accept[c], emit[c]})
          2'b10:   cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
          2'b01:   cnt_d[c] = cnt_q[c] - CNT_WIDTH'(1);
          default: cnt_d[c] = cnt_q[c];
        endcase
      end
      busy_d = busy_d | (cnt_d[c] != '0);
    end
  end

  // prevEn tracks the raw enable even during flush so burst detection stays correct afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_en <= '0;
      busy    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        stage_vld[c] <= '0;
        cnt_q[c]     <= '0;
        for (int s = 0; s < LATENCY; s++) stage_tag[c][s] <= '0;
      end
    end else begin
      prev_en <= readEnable;
      busy    <= busy_d;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
        if (flush) begin
          stage_vld[c] <= '0;
          for (int s = 0; s < LATENCY; s++) stage_tag[c][s] <= '0;
        end else begin
          stage_vld[c][0] <= accept[c];
          stage_tag[c][0] <= accept[c] ? readTag[c*TAG_WIDTH +: TAG_WIDTH] : '0;
          for (int s = 1; s < LATENCY; s++) begin
            stage_vld[c][s] <= stage_vld[c][s-1];
            stage_tag[c][s] <= stage_tag[c][s-1];
          end
        end
      end
    end
  end

  always_comb begin
    readValid = '0;
    validTag  = '0;
    inFlight  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      readValid[c]                        = stage_vld[c][LATENCY-1];
      validTag[c*TAG_WIDTH +: TAG_WIDTH]  = stage_tag[c][LATENCY-1];
      inFlight[c*CNT_WIDTH +: CNT_WIDTH]  = cnt_q[c];
    end
  end

endmodule

// File: tb/tb_read_valid_pipe.sv
// Scoreboard bench for read_valid_pipe: directed scenarios followed by random enables/burst/flush/reset.
module tb_read_valid_pipe;
  localparam int CH = 4;
  localparam int L  = 2;
  localparam int TW = 4;
  localparam int CW = $clog2(L + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic [CH-1:0]     readEnable;
  logic [CH*TW-1:0]  readTag;
  logic [CH-1:0]     burstMode;
  logic              flush;
  logic [CH-1:0]     readValid;
  logic [CH*TW-1:0]  validTag;
  logic [CH*CW-1:0]  inFlight;
  logic              busy;

  read_valid_pipe #(.CHANNELS(CH), .LATENCY(L), .TAG_WIDTH(TW)) dut (
    .clock(clock), .reset(reset), .readEnable(readEnable), .readTag(readTag),
    .burstMode(burstMode), .flush(flush), .readValid(readValid), .validTag(validTag),
    .inFlight(inFlight), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            ch;
    int            due;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          sb[$];
  logic [CH-1:0] mprev;
  int            cyc;
  int            n_pass;
  int            n_total;
  bit            chk_en;
  int            ch2_burst_v;
  int            ch2_pulse_v;
  int            ch0_flush_v;
  int            stray_v;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, obs, exp);
  endtask

  task automatic compare();
    int            cnt [CH];
    logic          ev  [CH];
    logic [TW-1:0] et  [CH];
    bit            any_busy;
    any_busy = 1'b0;
    for (int c = 0; c < CH; c++) begin
      cnt[c] = 0;
      ev[c]  = 1'b0;
      et[c]  = '0;
    end
    foreach (sb[i]) cnt[sb[i].ch]++;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      ev[sb[0].ch] = 1'b1;
      et[sb[0].ch] = sb[0].tag;
      void'(sb.pop_front());
    end
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("readValid[%0d]", c), 32'(readValid[c]), 32'(ev[c]));
        check($sformatf("validTag[%0d]", c), 32'(validTag[c*TW +: TW]), 32'(et[c]));
        check($sformatf("inFlight[%0d]", c), 32'(inFlight[c*CW +: CW]), 32'(cnt[c]));
        if (cnt[c] != 0) any_busy = 1'b1;
      end
      check("busy", 32'(busy), 32'(any_busy));
    end
    if (cyc >= 30 && cyc <= 38 && readValid[2] === 1'b1) ch2_burst_v++;
    if (cyc >= 40 && cyc <= 45 && readValid[2] === 1'b1) ch2_pulse_v++;
    if (cyc >= 51 && cyc <= 56 && readValid[0] === 1'b1) ch0_flush_v++;
    if (cyc >= 61 && cyc <= 62 && readValid !== '0) stray_v++;
  endtask

  task automatic step(input logic [CH-1:0] en, input logic [CH*TW-1:0] tg,
                      input logic [CH-1:0] bm, input logic fl, input logic rs);
    logic first;
    logic acc;
    readEnable = en;
    readTag    = tg;
    burstMode  = bm;
    flush      = fl;
    reset      = rs;
    @(negedge clock);
    compare();
    if (!rs) begin
      sb.delete();
      mprev = '0;
    end else begin
      if (fl) sb.delete();
      for (int c = 0; c < CH; c++) begin
        first = en[c] & ~mprev[c];
        acc   = en[c] & ~fl & ~(bm[c] & first);
        if (acc) sb.push_back('{ch: c, due: cyc + L, tag: tg[c*TW +: TW]});
      end
      mprev = en;
    end
    cyc++;
    chk_en = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [CH-1:0]    en;
    logic [CH*TW-1:0] tg;
    logic [CH-1:0]    bm;
    logic             fl;
    logic             rs;
    readEnable = '0; readTag = '0; burstMode = '0; flush = 1'b0; reset = 1'b0;
    mprev = '0; cyc = 0; n_pass = 0; n_total = 0; chk_en = 1'b0;
    ch2_burst_v = 0; ch2_pulse_v = 0; ch0_flush_v = 0; stray_v = 0;
    @(posedge clock);
    #1;

    for (int t = 0; t < 70; t++) begin
      en = '0; tg = '0; bm = '0; fl = 1'b0; rs = (t >= 3);
      if (t == 10) begin en[0] = 1'b1; tg[0 +: TW] = 4'h5; end
      if (t >= 20 && t <= 27) begin en[1] = 1'b1; tg[TW +: TW] = TW'(t - 20); end
      if (t >= 30 && t <= 33) begin en[2] = 1'b1; bm[2] = 1'b1; tg[2*TW +: TW] = TW'(t); end
      if (t == 40) begin en[2] = 1'b1; bm[2] = 1'b1; tg[2*TW +: TW] = 4'hA; end
      if (t == 50 || t == 51) begin en[0] = 1'b1; tg[0 +: TW] = TW'(t); end
      if (t == 51) fl = 1'b1;
      if (t >= 55 && t <= 64) begin en = '1; tg = (CH*TW)'($urandom); end
      if (t == 60) rs = 1'b0;
      step(en, tg, bm, fl, rs);
    end

    for (int t = 0; t < 400; t++) begin
      en = CH'($urandom);
      tg = (CH*TW)'($urandom);
      bm = CH'($urandom);
      fl = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 99) != 0);
      step(en, tg, bm, fl, rs);
    end
    for (int t = 0; t < L + 3; t++) step('0, '0, '0, 1'b0, 1'b1);

    check("ch2_burst_valids", 32'(ch2_burst_v), 32'd3);
    check("ch2_pulse_valids", 32'(ch2_pulse_v), 32'd0);
    check("ch0_flushed_valids", 32'(ch0_flush_v), 32'd0);
    check("stray_after_reset", 32'(stray_v), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
